// File: rtl/conv_fprop3_mul_arb.sv
// Round-robin arbiter sharing one unsigned multiplier among NUM_REQ requesters.
// Two-stage pipeline (operands, product) stalls as a whole when the result owner is not ready.
module conv_fprop3_mul_arb #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DIN_WIDTH  = 31,
  parameter int unsigned DOUT_WIDTH = 62
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*DIN_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*DIN_WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [DOUT_WIDTH-1:0]          rsp_data,
  output logic                           busy
);

  localparam int unsigned TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [DIN_WIDTH-1:0]  a_arr [NUM_REQ];
  logic [DIN_WIDTH-1:0]  b_arr [NUM_REQ];

  logic [TAG_W-1:0]      rr_ptr;
  logic                  s1_valid;
  logic [TAG_W-1:0]      s1_tag;
  logic [DIN_WIDTH-1:0]  s1_a;
  logic [DIN_WIDTH-1:0]  s1_b;
  logic                  s2_valid;
  logic [TAG_W-1:0]      s2_tag;
  logic [DOUT_WIDTH-1:0] s2_prod;

  logic                  ce;
  logic                  win_found;
  logic [TAG_W-1:0]      win_idx;
  logic                  grant;
  logic [DOUT_WIDTH-1:0] product;
  int unsigned           cand;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*DIN_WIDTH +: DIN_WIDTH];
    assign b_arr[g] = req_b[g*DIN_WIDTH +: DIN_WIDTH];
  end

  // Pipeline advances unless the held result's owner is refusing it
  assign ce = !(s2_valid && !rsp_ready[s2_tag]);

  // First valid requester at or after rr_ptr, wrapping
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_found && req_valid[TAG_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = TAG_W'(cand);
      end
    end
  end

  assign grant     = win_found && ce && !reset;
  assign req_ready = grant ? (NUM_REQ'(1) << win_idx) : '0;

  // The single shared multiplier
  assign product = DOUT_WIDTH'(s1_a) * DOUT_WIDTH'(s1_b);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr   <= '0;
      s1_valid <= 1'b0;
      s1_tag   <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s2_valid <= 1'b0;
      s2_tag   <= '0;
      s2_prod  <= '0;
    end else begin
      if (grant) begin
        if (win_idx == TAG_W'(NUM_REQ - 1)) rr_ptr <= '0;
        else                                rr_ptr <= win_idx + 1'b1;
      end
      if (ce) begin
        s1_valid <= grant;
        if (grant) begin
          s1_tag <= win_idx;
          s1_a   <= a_arr[win_idx];
          s1_b   <= b_arr[win_idx];
        end
        s2_valid <= s1_valid;
        s2_tag   <= s1_tag;
        s2_prod  <= product;
      end
    end
  end

  assign rsp_valid = s2_valid ? (NUM_REQ'(1) << s2_tag) : '0;
  assign rsp_data  = s2_prod;
  assign busy      = s1_valid | s2_valid;

endmodule

// File: tb/tb_conv_fprop3_mul_arb.sv
// Directed bench for conv_fprop3_mul_arb: inputs driven and outputs sampled on the falling edge.
module tb_conv_fprop3_mul_arb;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 31;
  localparam int unsigned DW = 62;

  logic              clk;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*W-1:0]    req_a;
  logic [N*W-1:0]    req_b;
  logic [N-1:0]      rsp_valid;
  logic [N-1:0]      rsp_ready;
  logic [DW-1:0]     rsp_data;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;

  conv_fprop3_mul_arb #(.NUM_REQ(N), .DIN_WIDTH(W), .DOUT_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  logic [63:0] fprod [N];

  initial begin
    reset     = 1'b1;
    req_valid = 4'hF;
    rsp_ready = 4'hF;
    req_a     = '0;
    req_b     = '0;

    // Reset holds every output low even with requests pending
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'h0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rst_rsp_data",  64'(rsp_data),  64'h0);
    check("rst_busy",      64'(busy),      64'h0);

    // Single issue: requester 2, 3*5
    reset     = 1'b0;
    req_valid = 4'b0100;
    set_op(2, 31'd3, 31'd5);
    #1 check("single_gnt", 64'(req_ready), 64'h4);
    @(negedge clk);
    req_valid = 4'b0000;
    check("single_busy_s1", 64'(busy), 64'h1);
    check("single_rv_early", 64'(rsp_valid), 64'h0);
    @(negedge clk);
    check("single_rv",   64'(rsp_valid), 64'h4);
    check("single_data", 64'(rsp_data),  64'd15);
    @(negedge clk);
    check("single_rv_after", 64'(rsp_valid), 64'h0);
    check("single_busy_after", 64'(busy), 64'h0);

    // Wrap-around: rr_ptr is 3 now, requesters 3 and 0 contend
    req_valid = 4'b1001;
    set_op(3, 31'd7, 31'd9);
    set_op(0, 31'd11, 31'd13);
    #1 check("wrap_gnt3", 64'(req_ready), 64'h8);
    @(negedge clk);
    check("wrap_gnt0", 64'(req_ready), 64'h1);
    @(negedge clk);
    req_valid = 4'b0000;
    check("wrap_rv3",   64'(rsp_valid), 64'h8);
    check("wrap_data3", 64'(rsp_data),  64'd63);
    @(negedge clk);
    check("wrap_rv0",   64'(rsp_valid), 64'h1);
    check("wrap_data0", 64'(rsp_data),  64'd143);
    @(negedge clk);
    check("wrap_idle", 64'(busy), 64'h0);

    // Reset mid-operation: rr_ptr=1, fill S1 and S2
    req_valid = 4'b0010;
    set_op(1, 31'd2, 31'd2);
    @(negedge clk);
    req_valid = 4'b0100;
    set_op(2, 31'd4, 31'd4);
    @(negedge clk);
    check("midrst_pre_rv", 64'(rsp_valid), 64'h2);
    check("midrst_pre_busy", 64'(busy), 64'h1);
    req_valid = 4'hF;
    reset     = 1'b1;
    #1;
    check("midrst_req_ready", 64'(req_ready), 64'h0);
    check("midrst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("midrst_rsp_data",  64'(rsp_data),  64'h0);
    check("midrst_busy",      64'(busy),      64'h0);
    @(negedge clk);

    // Fairness after reset release: all four held high for 8 grants
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      set_op(i, W'(i + 1), W'(100 + i));
      fprod[i] = 64'(i + 1) * 64'(100 + i);
    end
    for (int k = 0; k < 10; k++) begin
      if (k == 8) req_valid = 4'h0;
      #1;
      if (k < 8) check("fair_gnt", 64'(req_ready), 64'(1) << (k % 4));
      if (k < 2) check("fair_no_stale", 64'(rsp_valid), 64'h0);
      else begin
        check("fair_rv",   64'(rsp_valid), 64'(1) << ((k - 2) % 4));
        check("fair_data", 64'(rsp_data),  fprod[(k - 2) % 4]);
      end
      @(negedge clk);
    end
    check("fair_idle", 64'(busy), 64'h0);

    // Backpressure: requester 1 result held while rsp_ready[1]=0
    req_valid = 4'b0010;
    rsp_ready = 4'b1101;
    set_op(1, 31'd100, 31'd200);
    #1 check("bp_gnt1", 64'(req_ready), 64'h2);
    @(negedge clk);
    req_valid = 4'b0001;
    set_op(0, 31'd6, 31'd7);
    #1 check("bp_gnt0", 64'(req_ready), 64'h1);
    @(negedge clk);
    req_valid = 4'b1000;
    set_op(3, 31'd5, 31'd5);
    for (int j = 0; j < 5; j++) begin
      #1;
      check("bp_req_ready", 64'(req_ready), 64'h0);
      check("bp_rv",        64'(rsp_valid), 64'h2);
      check("bp_data",      64'(rsp_data),  64'd20000);
      check("bp_busy",      64'(busy),      64'h1);
      if (j < 4) @(negedge clk);
    end
    rsp_ready = 4'hF;
    #1 check("bp_release_gnt3", 64'(req_ready), 64'h8);
    @(negedge clk);
    req_valid = 4'b0000;
    check("bp_rv0",   64'(rsp_valid), 64'h1);
    check("bp_data0", 64'(rsp_data),  64'd42);
    @(negedge clk);
    check("bp_rv3",   64'(rsp_valid), 64'h8);
    check("bp_data3", 64'(rsp_data),  64'd25);
    @(negedge clk);
    check("bp_idle", 64'(busy), 64'h0);

    // Extremes: max*max and 0*max
    req_valid = 4'b0011;
    set_op(0, 31'h7FFFFFFF, 31'h7FFFFFFF);
    set_op(1, 31'h0, 31'h7FFFFFFF);
    #1 check("ext_gnt0", 64'(req_ready), 64'h1);
    @(negedge clk);
    req_valid = 4'b0010;
    check("ext_gnt1", 64'(req_ready), 64'h2);
    @(negedge clk);
    req_valid = 4'b0000;
    check("ext_rv0",   64'(rsp_valid), 64'h1);
    check("ext_max",   64'(rsp_data),  64'h3FFFFFFF00000001);
    @(negedge clk);
    check("ext_rv1",   64'(rsp_valid), 64'h2);
    check("ext_zero",  64'(rsp_data),  64'h0);
    @(negedge clk);
    check("ext_idle",  64'(busy), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_fprop3_mul_arb.md
CONV_FPROP3_MUL_ARB -- requirements
Module: conv_fprop3_mul_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one multiplier (2..8).
REQ-002 SHALL have parameter DIN_WIDTH, default 31, unsigned operand width.
REQ-003 SHALL have parameter DOUT_WIDTH, default 62, product width (2*DIN_WIDTH).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester operand-pair valid.
REQ-007 SHALL have port req_ready  output  NUM_REQ  per-requester grant; at most one bit high per cycle.
REQ-008 SHALL have port req_a  input  NUM_REQ*DIN_WIDTH  packed operand A; requester i at slice [i*DIN_WIDTH +: DIN_WIDTH].
REQ-009 SHALL have port req_b  input  NUM_REQ*DIN_WIDTH  packed operand B, same packing.
REQ-010 SHALL have port rsp_valid  output  NUM_REQ  one-hot result valid, bit = originating requester.
REQ-011 SHALL have port rsp_ready  input  NUM_REQ  per-requester result accept.
REQ-012 SHALL have port rsp_data  output  DOUT_WIDTH  unsigned product a*b.
REQ-013 SHALL have port busy  output  1  high when any pipeline stage holds a valid entry.

Function
REQ-014 SHALL contain exactly one multiplier: unsigned DIN_WIDTH x DIN_WIDTH, full DOUT_WIDTH result, no truncation or rounding.
REQ-015 SHALL implement a two-stage pipeline: S1 = registered operands + tag + valid; S2 = registered product + tag + valid.
REQ-016 SHALL define ce = !(s2_valid && !rsp_ready[s2_tag]); all S1/S2 registers update only when ce=1.
REQ-017 SHALL assert req_ready[i] combinationally only when ce=1, req_valid[i]=1, and i is the round-robin winner.
REQ-018 SHALL select the winner as the first requester with req_valid high, searching from rr_ptr upward, wrapping from NUM_REQ-1 to 0.
REQ-019 SHALL, on a grant to i, set rr_ptr to (i+1) mod NUM_REQ; rr_ptr SHALL be unchanged on cycles with no grant.
REQ-020 SHALL treat the handshake req_valid[i]&&req_ready[i] at edge T as issue; result SHALL present rsp_valid[i]=1 with rsp_data=a*b in cycle T+2 when ce stays 1.
REQ-021 SHALL, with no handshake on a ce=1 edge, load S1 valid=0 (bubble).
REQ-022 SHALL drive rsp_valid = s2_valid ? (1<<s2_tag) : 0; rsp_data = S2 product, held stable while rsp_valid high and rsp_ready low.
REQ-023 SHALL sustain throughput of one issue per cycle when rsp_ready of the result owner is high.
REQ-024 SHALL, when ce=0, freeze S1 and S2 contents and drive req_ready=0; no operand is lost or duplicated.
REQ-025 SHALL complete results in issue order; each issued pair produces exactly one rsp_valid pulse-accept.
REQ-026 SHALL allow simultaneous result accept (S2) and new issue (S1) in the same cycle.
REQ-027 SHALL drive busy = s1_valid | s2_valid.
REQ-028 SHALL handle operands 0 and 2^DIN_WIDTH-1 exactly (max product 2^62 - 2^32 + 1 for default widths).

Reset
REQ-029 SHALL on reset=1 immediately clear s1_valid, s2_valid, rr_ptr=0, S1/S2 data and tags=0, independent of clk.
REQ-030 SHALL hold req_ready=0, rsp_valid=0, rsp_data=0, busy=0 while reset=1.
REQ-031 SHALL discard in-flight operations on reset mid-operation; no result for them appears after reset release.
REQ-032 SHALL permit first grant on the first rising edge after reset deasserts.

Verification
REQ-033 SHALL cover single issue: requester 2 sends a=3, b=5 at edge T, rsp_ready all 1 -> rsp_valid=4'b0100, rsp_data=15 in cycle T+2, busy low after.
REQ-034 SHALL cover fairness: all four req_valid held high 8 cycles -> grants 0,1,2,3,0,1,2,3; rsp order matches.
REQ-035 SHALL cover backpressure: requester 1 result pending with rsp_ready[1]=0 for 5 cycles -> req_ready=0, rsp_data stable, S1 entry preserved and delivered after release.
REQ-036 SHALL cover extremes: a=b=0x7FFFFFFF -> rsp_data=0x3FFFFFFF00000001; a=0,b=0x7FFFFFFF -> 0.
REQ-037 SHALL cover reset mid-operation: assert reset with S1 and S2 valid -> all outputs 0 asynchronously, no stale rsp_valid after release, rr_ptr=0 (requester 0 wins first contest).
REQ-038 SHALL cover wrap-around: rr_ptr=3 with req_valid=4'b1001 -> grant 3, then grant 0.
